// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the uart_tx round-robin arbiter.
// FSM state encoding, default watchdog limit and small index helpers.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LAUNCH      = 3'd1,
    ST_WAIT_ACTIVE = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_RELEASE     = 3'd4
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester/serializer handshake bundle for uart_tx_arbiter.
// slave = arbiter side, master = system side (requesters plus uart_tx).
interface uart_tx_arb_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [7:0]           tx_writedata;
  logic                 tx_enable;
  logic                 tx_active;
  logic                 tx_done;
  logic                 busy;
  logic [IW-1:0]        owner;
  logic                 timeout;

  modport slave (
    input  req, req_data, tx_active, tx_done,
    output ack, tx_writedata, tx_enable, busy, owner, timeout
  );

  modport master (
    output req, req_data, tx_active, tx_done,
    input  ack, tx_writedata, tx_enable, busy, owner, timeout
  );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module uart_tx_arb_rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0]      rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;

  // rot_req[k] is the request that sits k positions after rr_ptr.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot_idx[gi] = IW'((int'(rr_ptr) + gi) % NUM_REQ);
    assign rot_req[gi] = req[rot_idx[gi]];
  end

  always_comb begin
    grant_valid = |rot_req;
    grant_idx   = rot_idx[0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) grant_idx = rot_idx[k];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sequencer sharing one uart_tx between NUM_REQ requesters.
// Optional watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic          clock,
  input logic          reset_n,
  uart_tx_arb_if.slave bus
);

  localparam int IW = idx_width(NUM_REQ);

  arb_state_t         state_reg, state_next;
  logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]      owner_reg, owner_next;
  logic [7:0]         data_reg, data_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic               enable_reg, enable_next;
  logic               timeout_reg, timeout_next;
  logic               busy_reg;
  logic               grant_valid;
  logic [IW-1:0]      grant_idx;
  logic               expire;

  uart_tx_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req         (bus.req),
    .rr_ptr      (rr_ptr_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          waiting;

  assign waiting = (state_reg == ST_WAIT_ACTIVE) || (state_reg == ST_WAIT_DONE);
  assign cnt_inc = cnt_reg + CW'(1);
  assign expire  = waiting && (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == ST_LAUNCH) cnt_next = '0;
    else if (waiting)           cnt_next = cnt_inc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_reg <= '0;
    else          cnt_reg <= cnt_next;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    owner_next   = owner_reg;
    data_next    = data_reg;
    ack_next     = '0;
    enable_next  = 1'b0;
    timeout_next = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        // Never start a frame while the serializer still reports activity
        // (e.g. a frame left running across a reset of this block).
        if (grant_valid && !bus.tx_active) begin
          owner_next          = grant_idx;
          data_next           = bus.req_data[8*int'(grant_idx) +: 8];
          ack_next[grant_idx] = 1'b1;
          enable_next         = 1'b1;
          state_next          = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_next = ST_WAIT_ACTIVE;
      ST_WAIT_ACTIVE: begin
        if (bus.tx_active) begin
          state_next = ST_WAIT_DONE;
        end else if (expire) begin
          timeout_next = 1'b1;
          rr_ptr_next  = IW'(rr_next(int'(owner_reg), NUM_REQ));
          state_next   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.tx_done || expire) begin
          rr_ptr_next  = IW'(rr_next(int'(owner_reg), NUM_REQ));
          timeout_next = !bus.tx_done;
          state_next   = bus.tx_done ? ST_RELEASE : ST_IDLE;
        end
      end
      ST_RELEASE: begin
        // Works for both pulse and level style done from the serializer.
        if (!bus.tx_done && !bus.tx_active) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= '0;
      owner_reg   <= '0;
      data_reg    <= '0;
      ack_reg     <= '0;
      enable_reg  <= 1'b0;
      timeout_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      owner_reg   <= owner_next;
      data_reg    <= data_next;
      ack_reg     <= ack_next;
      enable_reg  <= enable_next;
      timeout_reg <= timeout_next;
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  assign bus.ack          = ack_reg;
  assign bus.tx_writedata = data_reg;
  assign bus.tx_enable    = enable_reg;
  assign bus.busy         = busy_reg;
  assign bus.owner        = owner_reg;
  assign bus.timeout      = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter with a transaction-level
// reference model and a behavioural uart_tx stand-in.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int N = 4;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO        = 100;
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam int TO        = DEFAULT_TIMEOUT_CYCLES;
  localparam bit TIMEOUT_ON = 1'b0;
`endif
  localparam int M_HOLD = 0, M_DROP = 1, M_RAND = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  uart_tx_arb_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0, miscompares = 0, cyc = 0, mode = M_HOLD;

  // reference model state
  int         rr, exp_owner, m_wait;
  logic       exp_busy, exp_en, exp_to;
  logic [N-1:0] exp_ack;
  logic [7:0] exp_data;
  bit         m_launch, m_act, m_done;
  int         grants[$];
  logic [7:0] frames[$];

  // uart_tx stand-in timeline, in edge numbers
  int act_from = 0, act_to = 0, done_from = 0, done_to = 0;
  bit stuck = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rr = 0; exp_owner = 0; m_wait = 0;
    exp_busy = 0; exp_en = 0; exp_to = 0; exp_ack = '0; exp_data = '0;
    m_launch = 0; m_act = 0; m_done = 0;
  endtask

  task automatic stub_reset();
    act_from = 0; act_to = 0; done_from = 0; done_to = 0;
    bus.tx_active = 1'b0; bus.tx_done = 1'b0;
  endtask

  // Advance the model by one clock edge given the inputs present at that edge.
  task automatic model_edge(input logic [N-1:0] r, input logic [8*N-1:0] d,
                            input logic a, input logic dn);
    int pick;
    exp_ack = '0; exp_en = 0; exp_to = 0;
    if (!exp_busy) begin
      if (r != '0 && !a) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
          if (pick < 0 && r[(rr + k) % N]) pick = (rr + k) % N;
        end
        exp_owner = pick; exp_data = d[8*pick +: 8];
        exp_ack[pick] = 1'b1; exp_en = 1; exp_busy = 1;
        m_launch = 1; m_act = 0; m_done = 0; m_wait = 0;
        grants.push_back(pick);
      end
    end else if (m_launch) begin
      m_launch = 0;
    end else if (m_done) begin
      if (!a && !dn) exp_busy = 0;
    end else begin
      m_wait++;
      if (!m_act && a) m_act = 1;
      else if (m_act && dn) begin m_done = 1; rr = (exp_owner + 1) % N; end
      else if (TIMEOUT_ON && m_wait == TO) begin
        exp_to = 1; exp_busy = 0; rr = (exp_owner + 1) % N;
      end
    end
  endtask

  task automatic stub_drive();
    if (bus.tx_enable) begin
      frames.push_back(bus.tx_writedata);
      if (stuck) begin
        act_from = 0; act_to = 0; done_from = 0; done_to = 0;
      end else begin
        act_from  = cyc + 2 + int'($urandom_range(0, 2));
        act_to    = act_from + int'($urandom_range(3, 14));
        done_from = act_to - int'($urandom_range(0, 1));
        done_to   = done_from + int'($urandom_range(1, 3));
      end
    end
    bus.tx_active = (cyc + 1 >= act_from) && (cyc + 1 < act_to);
    bus.tx_done   = (cyc + 1 >= done_from) && (cyc + 1 < done_to);
  endtask

  task automatic stim_drive();
    for (int i = 0; i < N; i++) begin
      if (mode == M_DROP && bus.ack[i]) begin
        bus.req[i] = 1'b0;
        bus.req_data[8*i +: 8] = ~bus.req_data[8*i +: 8];
      end else if (mode == M_RAND) begin
        if (bus.ack[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          bus.req_data[8*i +: 8] = 8'($urandom);
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i] = 1'b1; bus.req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 63) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] r; logic [8*N-1:0] d; logic a, dn;
    r = bus.req; d = bus.req_data; a = bus.tx_active; dn = bus.tx_done;
    @(posedge clock);
    cyc++;
    model_edge(r, d, a, dn);
    #1;
    chk("ack", 32'(bus.ack), 32'(exp_ack));
    chk("tx_enable", 32'(bus.tx_enable), 32'(exp_en));
    chk("tx_writedata", 32'(bus.tx_writedata), 32'(exp_data));
    chk("owner", 32'(bus.owner), exp_owner);
    chk("busy", 32'(bus.busy), 32'(exp_busy));
    chk("timeout", 32'(bus.timeout), 32'(exp_to));
    stub_drive();
    chk("en_while_active", 32'(bus.tx_enable & bus.tx_active), 0);
    stim_drive();
  endtask

  task automatic run_until_grants(input string tag, input int n, input int budget);
    int start = grants.size();
    int c = 0;
    while (grants.size() < start + n && c < budget) begin step(); c++; end
    chk({tag, "_grant_count"}, grants.size(), start + n);
  endtask

  task automatic run_idle(input string tag, input int budget);
    int c = 0;
    do begin step(); c++; end while ((bus.busy || exp_busy) && c < budget);
    chk({tag, "_idle"}, 32'(bus.busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 0);
    chk({tag, "_tx_enable"}, 32'(bus.tx_enable), 0);
    chk({tag, "_tx_writedata"}, 32'(bus.tx_writedata), 0);
    chk({tag, "_owner"}, 32'(bus.owner), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 0);
  endtask

  initial begin
    int c;
    bus.req = '0; bus.req_data = '0;
    stub_reset(); model_reset();
    #12 chk_zero("por");
    @(negedge clock) reset_n = 1'b1;

    // single requester 1, byte AB; data flips the cycle after ack
    mode = M_DROP; grants.delete(); frames.delete();
    bus.req_data = {8'h00, 8'h00, 8'hAB, 8'h00}; bus.req = 4'b0010;
    step();
    chk("single_ack", 32'(bus.ack), 32'h2);
    chk("single_enable_latency", 32'(bus.tx_enable), 1);
    chk("single_byte", 32'(bus.tx_writedata), 32'hAB);
    run_idle("single", 100);
    chk("single_byte_held", 32'(bus.tx_writedata), 32'hAB);
    chk("single_frame", 32'(frames[0]), 32'hAB);

    // reset while the frame is in WAIT_DONE
    bus.req = 4'b0010;
    c = 0;
    do begin step(); c++; end while (!(m_act && !m_done) && c < 60);
    chk("mid_frame_reached", 32'(m_act && !m_done), 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    bus.req = '0; stub_reset(); model_reset();
    @(posedge clock); @(negedge clock) reset_n = 1'b1;

    // all four held: order restarts at 0 after reset
    mode = M_HOLD; grants.delete(); frames.delete();
    bus.req_data = {8'hAD, 8'hAC, 8'hAB, 8'hAA}; bus.req = 4'b1111;
    run_until_grants("all4", 5, 400);
    bus.req = '0;
    run_idle("all4", 100);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("all4_grant%0d", k), grants[k], k % 4);
      chk($sformatf("all4_frame%0d", k), 32'(frames[k]), 32'hAA + (k % 4));
    end

    // wrap: after a grant to 2, requests 0 and 2 give 0 then 2
    mode = M_DROP; grants.delete();
    bus.req = 4'b0100;
    run_until_grants("wrap_a", 1, 50);
    run_idle("wrap_a", 100);
    bus.req = 4'b0101;
    run_until_grants("wrap_b", 2, 200);
    run_idle("wrap_b", 100);
    chk("wrap_g0", grants[0], 2);
    chk("wrap_g1", grants[1], 0);
    chk("wrap_g2", grants[2], 2);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // serializer never answers: watchdog fires and the pointer skips the owner
    begin
      int e;
      stuck = 1; grants.delete();
      bus.req = 4'b0001;
      run_until_grants("to_launch", 1, 50);
      e = cyc; c = 0;
      do begin step(); c++; end while (!bus.timeout && c < 300);
      chk("to_latency", cyc - e, TO + 1);
      chk("to_busy", 32'(bus.busy), 0);
      stuck = 0;
      bus.req = 4'b0011;
      run_until_grants("to_next", 1, 50);
      chk("to_next_grant", grants[1], 1);
      run_idle("to_next", 100);
    end
`endif

    // randomized traffic
    mode = M_RAND; grants.delete();
    for (int k = 0; k < 3000; k++) step();
    mode = M_HOLD; bus.req = '0;
    run_idle("rand", 100);
    chk("rand_progress", 32'(grants.size() > 50), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx` serializer between `NUM_REQ` bus-side requesters. It accepts one byte per grant, launches it with a single-cycle `enable` pulse, then tracks the serializer's `active`/`done` handshake before serving the next requester. It sits between the bus peripherals and the `uart_tx` instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `TIMEOUT_CYCLES`, 65535, watchdog limit in clock cycles; used only with `UART_TX_ARB_TIMEOUT_EN`
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  level request per requester; held until matching `ack`
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i]; stable while `req[i]`=1
- `ack`  out  NUM_REQ  one-cycle pulse; byte of requester i accepted
- `tx_writedata`  out  8  byte to `uart_tx.writedata`
- `tx_enable`  out  1  one-cycle start pulse to `uart_tx.enable`
- `tx_active`  in  1  from `uart_tx.active`
- `tx_done`  in  1  from `uart_tx.done`
- `busy`  out  1  arbiter not in IDLE
- `owner`  out  clog2(NUM_REQ)  index of current/last granted requester
- `timeout`  out  1  one-cycle pulse on watchdog expiry

## Operation
- FSM states: IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE, RELEASE.
- IDLE: if any `req` bit set, select first set bit scanning from `rr_ptr` upward with wrap at NUM_REQ-1 -> 0; register `owner` and `tx_writedata` from that requester's slice; go LAUNCH. No request: stay.
- LAUNCH: `tx_enable`=1 and `ack[owner]`=1 for exactly this cycle; go WAIT_ACTIVE.
- WAIT_ACTIVE: on `tx_active`=1 go WAIT_DONE.
- WAIT_DONE: on `tx_done`=1 set `rr_ptr` = (`owner`+1) mod NUM_REQ; go RELEASE.
- RELEASE: when `tx_done`=0 and `tx_active`=0 go IDLE (tolerates level or pulse `done`).
- `tx_writedata` holds its value from grant until the next grant; requester may change `req_data` or drop `req` the cycle after `ack`.
- `req` changes outside IDLE are ignored until IDLE; requester dropping `req` before `ack` loses its slot without side effects.
- `busy` = 1 in every state except IDLE.
- Reset (any state, mid-byte included): state IDLE, `rr_ptr`=0, `owner`=0, `tx_writedata`=0, `tx_enable`=0, `ack`=0, `busy`=0, `timeout`=0. An in-flight `uart_tx` frame is not aborted by this block.

## Timing
- All outputs registered.
- `req` seen in IDLE at edge k -> `tx_enable`/`ack` high during cycle k+1 -> earliest `tx_active` sample at k+2.
- Arbitration overhead per byte: 2 cycles (IDLE, LAUNCH) plus 1 RELEASE cycle after `done` drops.
- Simultaneous requests: exactly one `ack` per grant; with all requesters active, grant order is 0,1,2,...,NUM_REQ-1,0.
- `tx_enable` is never asserted while `tx_active`=1.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined: counter (width clog2(TIMEOUT_CYCLES+1)) clears on LAUNCH, increments in WAIT_ACTIVE and WAIT_DONE; reaching TIMEOUT_CYCLES pulses `timeout` for one cycle, advances `rr_ptr` past `owner`, returns to IDLE.
- Not defined: no counter; `timeout` tied 0; WAIT_ACTIVE/WAIT_DONE wait indefinitely.

## Structure
- Package `uart_tx_arb_pkg`: FSM state typedef and encodings, default `TIMEOUT_CYCLES` constant.
- Sub-module `uart_tx_arb_rr_pick`: combinational rotate-priority picker (`req`, `rr_ptr` -> `grant_valid`, `grant_idx`).

## Test plan
- Reset mid-WAIT_DONE with `reset_n`=0 -> all outputs 0 immediately, state IDLE, next request served from requester 0.
- `req`=4'b0010, data 8'hAB, real `uart_tx` with bit period 16 -> one `ack[1]`, `tx_enable` 1 cycle after request sample, serial frame carries 8'hAB, `busy` falls 1 cycle after `done` drops.
- `req`=4'b1111 held, data AA/AB/AC/AD -> grants 0,1,2,3,0, frames AA,AB,AC,AD,AA, no `tx_enable` while `tx_active`=1.
- After grant to 2, `req`=4'b0101 -> next grant is 0 (wrap), then 2.
- `req_data` changed the cycle after `ack` -> `tx_writedata` unchanged until next grant.
- With `UART_TX_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=100, stubbed `tx_active` stuck 0 -> `timeout` pulses 100 cycles after LAUNCH, arbiter IDLE, next grant goes to `owner`+1.
